alu_control_mdu: RTL and testbench

//  Next-generation ALU control. Decodes {opcode, funct} into the 4-bit ALU operation code, as the single-cycle

---
 rtl/alu_ctrl_pkg.sv | 48 ++++
 rtl/mdu_iter.sv | 64 ++++++
 rtl/alu_control_mdu.sv | 147 ++++++++++++++
 tb/tb_alu_control_mdu.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_ctrl_pkg.sv
// ALU control / MDU shared definitions.
// ALU codes, opcode and funct encodings, MDU FSM states.
package alu_ctrl_pkg;

  localparam logic [3:0] ALU_ADD = 4'b1000;
  localparam logic [3:0] ALU_SUB = 4'b1001;
  localparam logic [3:0] ALU_AND = 4'b1100;
  localparam logic [3:0] ALU_OR  = 4'b1101;
  localparam logic [3:0] ALU_XOR = 4'b1111;
  localparam logic [3:0] ALU_SLT = 4'b0101;
  localparam logic [3:0] ALU_SLL = 4'b0001;
  localparam logic [3:0] ALU_NOP = 4'b0000;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;

  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_XOR   = 6'b100110;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_SLL   = 6'b000000;

  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ITER,
    S_FIX
  } mdu_state_e;

endpackage

// File: rtl/mdu_iter.sv
// Iterative unsigned multiply / restoring divide datapath.
// One step per cycle; hi/lo hold product or remainder/quotient.
module mdu_iter #(
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              step_i,
  input  logic              div_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o,
  output logic              done_o
);

  localparam int CW = $clog2(DATA_W + 1);

  logic [DATA_W-1:0] hi_q, lo_q, b_q;
  logic [DATA_W-1:0] hi_d, lo_d;
  logic              div_q;
  logic [CW-1:0]     cnt_q;
  logic [DATA_W:0]   sum, shl, diff;

  // One shift-add or shift-subtract step on the current state
  always_comb begin
    sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    shl  = {hi_q, lo_q[DATA_W-1]};
    diff = shl - {1'b0, b_q};
    hi_d = sum[DATA_W:1];
    lo_d = {sum[0], lo_q[DATA_W-1:1]};
    if (div_q) begin
      hi_d = diff[DATA_W] ? shl[DATA_W-1:0] : diff[DATA_W-1:0];
      lo_d = {lo_q[DATA_W-2:0], ~diff[DATA_W]};
    end
  end

  // Load on start, advance one step per enabled cycle
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hi_q  <= '0;
      lo_q  <= '0;
      b_q   <= '0;
      div_q <= 1'b0;
      cnt_q <= '0;
    end else if (start_i) begin
      hi_q  <= '0;
      lo_q  <= a_i;
      b_q   <= b_i;
      div_q <= div_i;
      cnt_q <= '0;
    end else if (step_i) begin
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign hi_o   = hi_q;
  assign lo_o   = lo_q;
  assign done_o = (cnt_q == CW'(DATA_W - 1));

endmodule

// File: rtl/alu_control_mdu.sv
// ALU control decode plus sequential multiply/divide unit.
// HI/LO registers, sign fix-up and pipeline stall generation.
module alu_control_mdu
  import alu_ctrl_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  input  logic              i_flush,
  input  logic [5:0]        i_Op,
  input  logic [5:0]        i_funct,
  input  logic [DATA_W-1:0] i_rs,
  input  logic [DATA_W-1:0] i_rt,
  output logic [CTRL_W-1:0] ALUCtrl,
  output logic [DATA_W-1:0] o_mdu_rd,
  output logic              o_busy,
  output logic              o_stall
);

  mdu_state_e        state_q;
  logic [DATA_W-1:0] hi_q, lo_q;
  logic              div_q, div0_q, nega_q, negb_q;

  logic              rtype, is_mdu, is_md, issue, start;
  logic              rs_neg, rt_neg;
  logic [DATA_W-1:0] a_mag, b_mag, it_hi, it_lo;
  logic              it_done;
  logic [2*DATA_W-1:0] prod_s;
  logic [DATA_W-1:0] hi_fix, lo_fix, rem_s, quo_s;

  // ALU operation decode
  always_comb begin
    ALUCtrl = ALU_NOP;
    if (i_Op == OP_RTYPE) begin
      unique case (i_funct)
        F_ADD:   ALUCtrl = ALU_ADD;
        F_SUB:   ALUCtrl = ALU_SUB;
        F_AND:   ALUCtrl = ALU_AND;
        F_OR:    ALUCtrl = ALU_OR;
        F_XOR:   ALUCtrl = ALU_XOR;
        F_SLT:   ALUCtrl = ALU_SLT;
        F_SLL:   ALUCtrl = ALU_SLL;
        default: ALUCtrl = ALU_NOP;
      endcase
    end else begin
      unique case (i_Op)
        OP_ADDI, OP_LW, OP_SW: ALUCtrl = ALU_ADD;
        OP_BEQ, OP_BNE:        ALUCtrl = ALU_SUB;
        OP_SLTI:               ALUCtrl = ALU_SLT;
        OP_ANDI:               ALUCtrl = ALU_AND;
        OP_ORI:                ALUCtrl = ALU_OR;
        OP_XORI:               ALUCtrl = ALU_XOR;
        default:               ALUCtrl = ALU_NOP;
      endcase
    end
  end

  assign rtype   = (i_Op == OP_RTYPE);
  assign is_md   = rtype & (i_funct[5:2] == 4'b0110);
  assign is_mdu  = is_md | (rtype & (i_funct[5:2] == 4'b0100));
  assign o_busy  = (state_q != S_IDLE);
  assign o_stall = i_valid & is_mdu & (o_busy | i_rst);
  assign issue   = i_valid & is_mdu & ~o_stall;
  assign start   = issue & is_md & ~i_flush;

  // funct[0] clear selects the signed forms
  assign rs_neg = ~i_funct[0] & i_rs[DATA_W-1];
  assign rt_neg = ~i_funct[0] & i_rt[DATA_W-1];
  assign a_mag  = rs_neg ? -i_rs : i_rs;
  assign b_mag  = rt_neg ? -i_rt : i_rt;

  mdu_iter #(.DATA_W(DATA_W)) u_iter (
    .clk_i   (i_clk),
    .rst_i   (i_rst),
    .start_i (start),
    .step_i  (state_q == S_ITER),
    .div_i   (i_funct[1]),
    .a_i     (a_mag),
    .b_i     (b_mag),
    .hi_o    (it_hi),
    .lo_o    (it_lo),
    .done_o  (it_done)
  );

  // Sign fix-up of the raw magnitude result
  always_comb begin
    prod_s = {it_hi, it_lo};
    if (nega_q ^ negb_q) prod_s = -{it_hi, it_lo};
    rem_s = nega_q ? -it_hi : it_hi;
    quo_s = (nega_q ^ negb_q) ? -it_lo : it_lo;
    hi_fix = prod_s[2*DATA_W-1:DATA_W];
    lo_fix = prod_s[DATA_W-1:0];
    if (div_q) begin
      hi_fix = rem_s;
      lo_fix = div0_q ? '1 : quo_s;
    end
  end

  // MDU sequencing and HI/LO update
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      div_q   <= 1'b0;
      div0_q  <= 1'b0;
      nega_q  <= 1'b0;
      negb_q  <= 1'b0;
    end else if (i_flush) begin
      state_q <= S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (issue && is_md) begin
            state_q <= S_ITER;
            div_q   <= i_funct[1];
            div0_q  <= (i_rt == '0);
            nega_q  <= rs_neg;
            negb_q  <= rt_neg;
          end else if (issue && i_funct == F_MTHI) begin
            hi_q <= i_rs;
          end else if (issue && i_funct == F_MTLO) begin
            lo_q <= i_rs;
          end
        end
        S_ITER: if (it_done) state_q <= S_FIX;
        S_FIX: begin
          hi_q    <= hi_fix;
          lo_q    <= lo_fix;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // HI/LO read port for MFHI/MFLO
  always_comb begin
    o_mdu_rd = '0;
    if (rtype && i_funct == F_MFHI) o_mdu_rd = hi_q;
    if (rtype && i_funct == F_MFLO) o_mdu_rd = lo_q;
  end

endmodule

// File: tb/tb_alu_control_mdu.sv
// Directed self-checking bench for alu_control_mdu.
// Decode, MDU results, latency, stall, flush, reset.
module tb_alu_control_mdu;

  logic        clk = 1'b0;
  logic        rst, valid, flush;
  logic [5:0]  op, funct;
  logic [31:0] rs, rt;
  logic [3:0]  alu;
  logic [31:0] rd;
  logic        busy, stall;

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_control_mdu #(.DATA_W(32), .CTRL_W(4)) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_valid  (valid),
    .i_flush  (flush),
    .i_Op     (op),
    .i_funct  (funct),
    .i_rs     (rs),
    .i_rt     (rt),
    .ALUCtrl  (alu),
    .o_mdu_rd (rd),
    .o_busy   (busy),
    .o_stall  (stall)
  );

  task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    valid = 1'b1; op = 6'd0; funct = f; rs = a; rt = b;
    @(negedge clk);
    valid = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic rd_hilo(output logic [31:0] h, output logic [31:0] l);
    valid = 1'b0; op = 6'd0;
    funct = 6'b010000; #1 h = rd;
    funct = 6'b010010; #1 l = rd;
  endtask

  task automatic test_reset;
    logic [31:0] h, l;
    rst = 1'b1; valid = 1'b0; flush = 1'b0;
    op = 6'd0; funct = 6'd0; rs = '0; rt = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy got=%b exp=0", busy); end
    valid = 1'b1; funct = 6'b010000; #1;
    checks++;
    if (stall !== 1'b1) begin errs++; $display("FAIL reset_stall got=%b exp=1", stall); end
    rd_hilo(h, l);
    checks++;
    if (h !== 32'h0 || l !== 32'h0) begin
      errs++; $display("FAIL reset_hilo got=%h/%h exp=0/0", h, l);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_decode;
    logic [5:0] ops [7]   = '{6'd0, 6'd0, 6'd0, 6'b001101, 6'b000100, 6'b100011, 6'b111111};
    logic [5:0] fns [7]   = '{6'b100010, 6'b011000, 6'b101010, 6'b000000, 6'b0, 6'b0, 6'b0};
    logic [3:0] exps [7]  = '{4'b1001, 4'b0000, 4'b0101, 4'b1101, 4'b1001, 4'b1000, 4'b0000};
    for (int i = 0; i < 7; i++) begin
      valid = 1'b0; op = ops[i]; funct = fns[i]; #1;
      checks++;
      if (alu !== exps[i]) begin
        errs++; $display("FAIL decode_%0d got=%b exp=%b", i, alu, exps[i]);
      end
    end
  endtask

  task automatic test_mult;
    logic [31:0] h, l;
    int n;
    issue(6'b011000, 32'hFFFFFFFD, 32'd7);
    wait_idle(n);
    checks++;
    if (n !== 33) begin errs++; $display("FAIL mult_latency got=%0d exp=33", n); end
    rd_hilo(h, l);
    checks++;
    if (h !== 32'hFFFFFFFF || l !== 32'hFFFFFFEB) begin
      errs++; $display("FAIL mult_neg got=%h/%h exp=ffffffff/ffffffeb", h, l);
    end
    issue(6'b011001, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_idle(n);
    rd_hilo(h, l);
    checks++;
    if (h !== 32'hFFFFFFFE || l !== 32'h00000001) begin
      errs++; $display("FAIL multu_max got=%h/%h exp=fffffffe/00000001", h, l);
    end
  endtask

  task automatic test_div;
    logic [31:0] h, l;
    int n;
    issue(6'b011010, 32'hFFFFFFF9, 32'd2);
    wait_idle(n);
    rd_hilo(h, l);
    checks++;
    if (h !== 32'hFFFFFFFF || l !== 32'hFFFFFFFD) begin
      errs++; $display("FAIL div_neg got=%h/%h exp=ffffffff/fffffffd", h, l);
    end
    issue(6'b011011, 32'd7, 32'd0);
    wait_idle(n);
    checks++;
    if (n !== 33) begin errs++; $display("FAIL div0_latency got=%0d exp=33", n); end
    rd_hilo(h, l);
    checks++;
    if (h !== 32'h7 || l !== 32'hFFFFFFFF) begin
      errs++; $display("FAIL divu_zero got=%h/%h exp=00000007/ffffffff", h, l);
    end
    issue(6'b011010, 32'h80000000, 32'hFFFFFFFF);
    wait_idle(n);
    rd_hilo(h, l);
    checks++;
    if (h !== 32'h0 || l !== 32'h80000000) begin
      errs++; $display("FAIL div_ovf got=%h/%h exp=00000000/80000000", h, l);
    end
    issue(6'b011011, 32'd100, 32'd7);
    wait_idle(n);
    rd_hilo(h, l);
    checks++;
    if (h !== 32'd2 || l !== 32'd14) begin
      errs++; $display("FAIL divu_100_7 got=%h/%h exp=00000002/0000000e", h, l);
    end
  endtask

  task automatic test_back_to_back;
    int n;
    @(negedge clk);
    valid = 1'b1; op = 6'd0; funct = 6'b011000; rs = 32'd5; rt = 32'd6;
    @(negedge clk);
    funct = 6'b010010;
    n = 0;
    while (stall && n < 200) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (n !== 33) begin errs++; $display("FAIL mflo_stall_cycles got=%0d exp=33", n); end
    checks++;
    if (rd !== 32'd30) begin errs++; $display("FAIL mflo_after_stall got=%h exp=0000001e", rd); end
    valid = 1'b0;
    issue(6'b011000, 32'd2, 32'd3);
    valid = 1'b1; funct = 6'b100000; #1;
    checks++;
    if (stall !== 1'b0 || alu !== 4'b1000 || busy !== 1'b1) begin
      errs++; $display("FAIL add_while_busy got=stall%b alu%b busy%b exp=stall0 alu1000 busy1",
                       stall, alu, busy);
    end
    valid = 1'b0;
    wait_idle(n);
  endtask

  task automatic test_flush_reset;
    logic [31:0] h, l;
    int n;
    issue(6'b010001, 32'hA5A5A5A5, 32'd0);
    issue(6'b010011, 32'h5A5A5A5A, 32'd0);
    issue(6'b011011, 32'd100, 32'd7);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checks++;
    if (busy !== 1'b0) begin errs++; $display("FAIL flush_idle got=%b exp=0", busy); end
    repeat (40) @(negedge clk);
    rd_hilo(h, l);
    checks++;
    if (h !== 32'hA5A5A5A5 || l !== 32'h5A5A5A5A) begin
      errs++; $display("FAIL flush_hold got=%h/%h exp=a5a5a5a5/5a5a5a5a", h, l);
    end
    issue(6'b011010, 32'd100, 32'd7);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0) begin errs++; $display("FAIL rst_mid_busy got=%b exp=0", busy); end
    repeat (40) @(negedge clk);
    wait_idle(n);
    rd_hilo(h, l);
    checks++;
    if (h !== 32'h0 || l !== 32'h0) begin
      errs++; $display("FAIL rst_mid_hilo got=%h/%h exp=0/0", h, l);
    end
  endtask

  task automatic test_mthi_mfhi;
    @(negedge clk);
    valid = 1'b1; op = 6'd0; funct = 6'b010001; rs = 32'h12345678;
    @(negedge clk);
    funct = 6'b010000; rs = 32'd0; #1;
    checks++;
    if (rd !== 32'h12345678 || stall !== 1'b0) begin
      errs++; $display("FAIL mthi_mfhi got=%h stall%b exp=12345678 stall0", rd, stall);
    end
    valid = 1'b0;
  endtask

  initial begin
    test_reset;
    test_decode;
    test_mult;
    test_div;
    test_back_to_back;
    test_flush_reset;
    test_mthi_mfhi;
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
